// File: rtl/puf_resp_collector.sv
// PUF comparison sequencer: walks RESP_BITS counter pairs through a single
// magnitude comparator, builds the response word and counts tie results.
module puf_resp_collector #(
   parameter int RESP_BITS = 32,
   parameter int CNT_W     = 32,
   parameter int TIMEOUT   = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic [$clog2(RESP_BITS)-1:0] pair_idx,
   input  logic [CNT_W-1:0]             cnt_a,
   input  logic [CNT_W-1:0]             cnt_b,
   output logic                         comp_en,
   output logic [CNT_W-1:0]             comp_num1,
   output logic [CNT_W-1:0]             comp_num2,
   input  logic                         comp_done,
   input  logic [1:0]                   comp_result,
   output logic [RESP_BITS-1:0]         resp,
   output logic [$clog2(RESP_BITS):0]   tie_cnt,
   output logic                         resp_valid,
   output logic                         err
);

   localparam int PW = $clog2(RESP_BITS);
   localparam int TW = PW + 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(RESP_BITS - 1);
   localparam logic [7:0]    TMO_LIM  = 8'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, FETCH, COMP, WAIT, FIN} state_t;

   state_t     state, state_nx;
   logic [7:0] tmo_cnt;
   logic       last_pair;
   logic       tmo_hit;

   assign last_pair = (pair_idx == LAST_IDX);
   assign tmo_hit   = ((tmo_cnt + 8'd1) == TMO_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      comp_en    = 1'b0;
      resp_valid = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: state_nx = COMP;
         COMP: begin
            comp_en  = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            if (comp_done) begin
               state_nx = last_pair ? FIN : FETCH;
            end else if (tmo_hit) begin
               state_nx = FIN;
            end
         end
         FIN: begin
            resp_valid = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The comparator only sees operands during its enable cycle.
   assign comp_num1 = comp_en ? cnt_a : '0;
   assign comp_num2 = comp_en ? cnt_b : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         pair_idx <= '0;
         resp     <= '0;
         tie_cnt  <= '0;
         err      <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pair_idx <= '0;
                  resp     <= '0;
                  tie_cnt  <= '0;
                  err      <= 1'b0;
               end
            end
            COMP: tmo_cnt <= '0;
            WAIT: begin
               if (comp_done) begin
                  // Result 10 is illegal: flag it and record a 0 bit.
                  resp[pair_idx] <= (comp_result == 2'b11);
                  if (comp_result == 2'b01) tie_cnt <= tie_cnt + TW'(1);
                  if (comp_result == 2'b10) err <= 1'b1;
                  if (!last_pair) pair_idx <= pair_idx + PW'(1);
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (tmo_hit) err <= 1'b1;
               end
            end
            FIN: pair_idx <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_resp_collector.sv
// Bench for puf_resp_collector: models the counter bank and comparator, checks
// table-driven and randomized runs against a reference model of the response rules.
module tb_puf_resp_collector;
   localparam int RB  = 32;
   localparam int CW  = 32;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic [4:0]    pair_idx;
   logic [CW-1:0] cnt_a = '0, cnt_b = '0;
   logic          comp_en;
   logic [CW-1:0] comp_num1, comp_num2;
   logic          comp_done = 1'b0;
   logic [1:0]    comp_result = 2'b00;
   logic [RB-1:0] resp;
   logic [5:0]    tie_cnt;
   logic          resp_valid;
   logic          err;

   puf_resp_collector #(.RESP_BITS(RB), .CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .pair_idx(pair_idx),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .comp_en(comp_en), .comp_num1(comp_num1),
      .comp_num2(comp_num2), .comp_done(comp_done), .comp_result(comp_result),
      .resp(resp), .tie_cnt(tie_cnt), .resp_valid(resp_valid), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [CW-1:0] a_arr [RB];
   logic [CW-1:0] b_arr [RB];
   int stuck_p = -1;
   int inj_p   = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counter bank answers one cycle after pair_idx; comparator answers one
   // cycle after comp_en, optionally stuck or returning the illegal code 10.
   initial begin
      logic          en_s;
      logic [CW-1:0] n1, n2;
      int            p;
      forever begin
         @(negedge clk);
         en_s = comp_en; n1 = comp_num1; n2 = comp_num2; p = int'(pair_idx);
         @(posedge clk);
         #1;
         cnt_a = a_arr[p];
         cnt_b = b_arr[p];
         comp_done   = en_s && (p != stuck_p);
         comp_result = 2'b00;
         if (comp_done) begin
            if (p == inj_p)    comp_result = 2'b10;
            else if (n1 > n2)  comp_result = 2'b11;
            else if (n1 == n2) comp_result = 2'b01;
         end
      end
   end

   function automatic void model(input int s, input int inj, output logic [31:0] r,
                                 output int t, output bit e, output int lat, output int nc);
      r = '0; t = 0; e = 0; lat = 3 * RB + 1; nc = RB;
      for (int i = 0; i < RB; i++) begin
         if (i == s) begin
            e = 1; lat = 3 * i + 2 + TMO + 1; nc = i + 1;
            break;
         end
         if (i == inj) e = 1;
         else if (a_arr[i] > b_arr[i]) r[i] = 1'b1;
         else if (a_arr[i] == b_arr[i]) t++;
      end
   endfunction

   task automatic fill(input int pat);
      for (int i = 0; i < RB; i++) begin
         case (pat)
            0: begin a_arr[i] = CW'(i + 100); b_arr[i] = 100; end
            1: begin a_arr[i] = 777; b_arr[i] = 777; end
            2: begin
               a_arr[i] = (i % 2 == 0) ? 200 : 100;
               b_arr[i] = (i % 2 == 0) ? 100 : 200;
            end
            default: begin
               a_arr[i] = $urandom;
               b_arr[i] = ($urandom_range(0, 3) == 0) ? a_arr[i] : $urandom;
            end
         endcase
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pidx"}, pair_idx, 0);
      check({tag, "_comp"}, {comp_en, comp_num1, comp_num2}, 0);
      check({tag, "_resp"}, resp, 0);
      check({tag, "_tie"}, tie_cnt, 0);
      check({tag, "_valid_err"}, {resp_valid, err}, 0);
   endtask

   // Runs one start request; cycle k is the cycle after edge k-1 (start at edge 0).
   task automatic do_run(input int xs1, input int xs2, input int rst_at,
                         output int lat, output int nvalid, output int ncomp, output int b2b,
                         output int nbad, output logic busy_c1, output logic err_c1,
                         output logic busy_after, output logic [31:0] r, output int t,
                         output logic e);
      logic prev_en;
      lat = -1; nvalid = 0; ncomp = 0; b2b = 0; nbad = 0; prev_en = 0;
      busy_c1 = 0; err_c1 = 1; busy_after = 1; r = '0; t = 0; e = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin busy_c1 = busy; err_c1 = err; end
         if (comp_en) begin
            ncomp++;
            if (prev_en) b2b++;
         end
         if (!comp_en && (comp_num1 != 0 || comp_num2 != 0)) nbad++;
         prev_en = comp_en;
         if (resp_valid) begin
            nvalid++;
            if (lat < 0) lat = cyc;
            r = resp; t = int'(tie_cnt); e = err;
         end
         if (lat > 0 && cyc == lat + 1) busy_after = busy;
         start = (cyc == xs1 || cyc == xs2);
         if (rst_at > 0 && cyc == rst_at + 1) begin
            check_zero("midrst");
            rst = 1'b0;
         end
         if (cyc == rst_at) rst = 1'b1;
         if (rst_at < 0 && lat > 0 && cyc >= lat + 2) break;
      end
      start = 1'b0;
   endtask

   typedef struct {
      int          pat;
      int          stuck;   // -2 picks a random pair
      int          inj;     // -2 picks a random pair
      bit          use_model;
      logic [31:0] e_resp;
      int          e_tie;
      bit          e_err;
      int          e_lat;
      int          e_ncomp;
   } vec_t;

   initial begin
      vec_t        vecs [10];
      int          lat, nvalid, ncomp, b2b, nbad, t, m_tie, m_lat, m_nc;
      logic        busy_c1, err_c1, busy_after, e;
      logic [31:0] r, m_resp;
      bit          m_err;

      vecs[0] = '{0, -1, -1, 0, 32'hFFFF_FFFE, 1,  0, 97,  32};
      vecs[1] = '{1, -1, -1, 0, 32'h0000_0000, 32, 0, 97,  32};
      vecs[2] = '{2, -1, -1, 0, 32'h5555_5555, 0,  0, 97,  32};
      vecs[3] = '{2,  5, -1, 0, 32'h0000_0015, 0,  1, 33,  6};
      vecs[4] = '{0, -1,  3, 0, 32'hFFFF_FFF6, 1,  1, 97,  32};
      vecs[5] = '{0,  0, -1, 0, 32'h0000_0000, 0,  1, 18,  1};
      vecs[6] = '{1, 31, -1, 0, 32'h0000_0000, 31, 1, 111, 32};
      vecs[7] = '{3, -1, -1, 1, 0, 0, 0, 0, 0};
      vecs[8] = '{3, -1, -2, 1, 0, 0, 0, 0, 0};
      vecs[9] = '{3, -2, -1, 1, 0, 0, 0, 0, 0};

      fill(0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check_zero("reset");

      for (int v = 0; v < 10; v++) begin
         fill(vecs[v].pat);
         stuck_p = (vecs[v].stuck == -2) ? int'($urandom_range(0, RB - 1)) : vecs[v].stuck;
         inj_p   = (vecs[v].inj == -2)   ? int'($urandom_range(0, RB - 1)) : vecs[v].inj;
         if (vecs[v].use_model) begin
            model(stuck_p, inj_p, m_resp, m_tie, m_err, m_lat, m_nc);
            vecs[v].e_resp = m_resp; vecs[v].e_tie = m_tie; vecs[v].e_err = m_err;
            vecs[v].e_lat = m_lat; vecs[v].e_ncomp = m_nc;
         end
         do_run(-1, -1, -1, lat, nvalid, ncomp, b2b, nbad, busy_c1, err_c1, busy_after, r, t, e);
         check($sformatf("v%0d_lat", v), lat, vecs[v].e_lat);
         check($sformatf("v%0d_nvalid", v), nvalid, 1);
         check($sformatf("v%0d_ncomp", v), ncomp, vecs[v].e_ncomp);
         check($sformatf("v%0d_b2b_nbad", v), {b2b, nbad}, 0);
         check($sformatf("v%0d_resp", v), r, vecs[v].e_resp);
         check($sformatf("v%0d_tie", v), t, vecs[v].e_tie);
         check($sformatf("v%0d_err", v), e, vecs[v].e_err);
         check($sformatf("v%0d_c1", v), {busy_c1, err_c1}, 2'b10);
         check($sformatf("v%0d_busy_after", v), busy_after, 0);
         check($sformatf("v%0d_resp_hold", v), resp, vecs[v].e_resp);
         check($sformatf("v%0d_pidx_idle", v), pair_idx, 0);
      end
      stuck_p = -1; inj_p = -1;

      fill(2);
      do_run(10, 40, -1, lat, nvalid, ncomp, b2b, nbad, busy_c1, err_c1, busy_after, r, t, e);
      check("xstart_nvalid", nvalid, 1);
      check("xstart_lat", lat, 97);
      check("xstart_resp", r, 32'h5555_5555);
      check("xstart_ncomp", ncomp, 32);

      fill(0);
      do_run(-1, -1, 50, lat, nvalid, ncomp, b2b, nbad, busy_c1, err_c1, busy_after, r, t, e);
      check("midrst_nvalid", nvalid, 0);
      check_zero("postrst");

      do_run(-1, -1, -1, lat, nvalid, ncomp, b2b, nbad, busy_c1, err_c1, busy_after, r, t, e);
      check("rerun_resp", r, 32'hFFFF_FFFE);
      check("rerun_lat", lat, 97);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/puf_resp_collector.md
# puf_resp_collector

Comparison sequencer for the PUF IP. It reads pairs of ring-oscillator count values from the counter bank and drives them one pair at a time into the 32-bit magnitude comparator through its `comp_en`/`done`/`result` handshake. It collects one response bit per pair into a RESP_BITS-wide response word and tallies tie results. It sits between the RO counter bank and the PUF response register/bus interface.

## Interface
- RESP_BITS, 32, response bits per run; one counter pair per bit; power of two, 2..64
- CNT_W, 32, count width; must equal the comparator operand width
- TIMEOUT, 15, maximum cycles spent in WAIT before error; 1..255
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  single-cycle run request; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- pair_idx  out  $clog2(RESP_BITS)  pair index to counter bank; bank returns counters 2*pair_idx and 2*pair_idx+1
- cnt_a  in  CNT_W  count of counter 2*pair_idx; valid one cycle after pair_idx is presented
- cnt_b  in  CNT_W  count of counter 2*pair_idx+1; same timing as cnt_a
- comp_en  out  1  comparator enable; high for exactly one cycle per pair
- comp_num1  out  CNT_W  cnt_a pass-through while comp_en is high; 0 otherwise
- comp_num2  out  CNT_W  cnt_b pass-through while comp_en is high; 0 otherwise
- comp_done  in  1  comparator done, arrives one cycle after comp_en
- comp_result  in  2  comparator result: 11 = num1>num2, 01 = equal, 00 = less
- resp  out  RESP_BITS  collected response; held stable until the next start
- tie_cnt  out  $clog2(RESP_BITS)+1  number of 01 results in the last run
- resp_valid  out  1  one-cycle pulse when resp/tie_cnt are final
- err  out  1  sticky; set on timeout or on result 10; cleared by start or rst

## Operation
- States: IDLE, FETCH, COMP, WAIT, FIN.
- IDLE: when start=1, clear resp, tie_cnt, err and pair_idx, then go to FETCH.
- FETCH: pair_idx is stable; go to COMP.
- COMP: comp_en=1, comp_num1=cnt_a, comp_num2=cnt_b; clear the timeout counter; go to WAIT.
- WAIT, comp_done=1:
  - bit = (comp_result==11); resp[pair_idx] <= bit.
  - result 01 increments tie_cnt.
  - result 10 sets err, writes bit 0 and continues.
  - If pair_idx==RESP_BITS-1, go to FIN; otherwise increment pair_idx and go to FETCH.
- WAIT, comp_done=0: increment the timeout counter. When it reaches TIMEOUT, set err and go to FIN. Unfilled resp bits stay 0.
- FIN: resp_valid=1 for one cycle, then go to IDLE. pair_idx returns to 0.
- start while busy is ignored; it does not restart the run or extend it.
- comp_en is never high in two consecutive cycles. The comparator clears its result when enable drops, so comp_result is sampled only in the WAIT cycle with comp_done=1.

## Timing
- Reset values: busy=0, pair_idx=0, comp_en=0, comp_num1=0, comp_num2=0, resp=0, tie_cnt=0, resp_valid=0, err=0, state IDLE.
- rst asserted mid-run: all outputs reach reset values on the next edge. The partial response is discarded and no resp_valid pulse is produced.
- Each bit takes 3 cycles (FETCH, COMP, WAIT) with a nominal comparator.
- start sampled at edge 0 gives busy high from cycle 1 and resp_valid high in cycle 3*RESP_BITS+1. busy falls in the following cycle.
- A timeout run ends TIMEOUT+1 cycles after the stuck COMP cycle.
- tie_cnt reaches RESP_BITS when every pair ties; its width covers that value without overflow.

## Test plan
- RESP_BITS=32; cnt_a=pair_idx+100, cnt_b=100 (pair 0 ties) -> resp=0xFFFFFFFE, tie_cnt=1, err=0, resp_valid in cycle 97.
- All pairs equal -> resp=0, tie_cnt=32, err=0.
- Alternating cnt_a>cnt_b on even pairs, < on odd pairs -> resp=0x55555555; comp_en pulses exactly 32 times, never back-to-back.
- comp_done held 0 at pair 5 -> err=1, resp holds bits 0..4 only, resp_valid TIMEOUT+1 cycles after the pair-5 comp_en.
- start pulses at cycles 10 and 40 of a run -> ignored; one resp_valid only. rst at cycle 50 -> all outputs 0 on the next edge, no resp_valid.
- Injected comp_result=10 on pair 3 -> err=1, resp[3]=0, run completes normally.
